// File: rtl/qsys_arduino_irq_in_if.sv
// rtl/qsys_arduino_irq_in_if.sv - Avalon-MM slave register bus for the Arduino IRQ input port
interface qsys_arduino_irq_in_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/qsys_arduino_irq_in.sv
// rtl/qsys_arduino_irq_in.sv - Arduino request-line input PIO: sync, edge capture, registered IRQ
// Optional per-line debounce filter enabled by defining ARDUINO_IRQ_DEBOUNCE_EN.
module qsys_arduino_irq_in #(
    parameter int WIDTH           = 1,
    parameter int SYNC_STAGES     = 2,
    parameter int EDGE_TYPE       = 0,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    qsys_arduino_irq_in_if.slave  avs,
    input  logic [WIDTH-1:0]      in_port,
    output logic                  irq
);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_s;
    logic [WIDTH-1:0] filt;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] edge_q, edge_d;
    logic [WIDTH-1:0] rise, fall, ev, clr;
    logic             irq_q, irq_d;
    logic             wr_en;
    logic             unused_wdata;

    assign wr_en        = avs.chipselect & ~avs.write_n;
    assign unused_wdata = ^avs.writedata;

    // Bits are synchronised independently; multi-bit coherency is not needed for request lines.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];

`ifdef ARDUINO_IRQ_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];
    logic [WIDTH-1:0] filt_q, filt_d;

    // The filtered value only follows the synchronised line after it has disagreed for a full window.
    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync_s[i] != filt_q[i]) begin
                if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    filt_d[i] = sync_s[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            filt_q <= filt_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign filt = filt_q;
`else
    assign filt = sync_s;
`endif

    assign rise = filt & ~prev_q;
    assign fall = ~filt & prev_q;

    always_comb begin
        case (EDGE_TYPE)
            0:       ev = rise;
            1:       ev = fall;
            default: ev = rise | fall;
        endcase
    end

    // A new event outranks a same-cycle software clear so no edge is ever lost.
    always_comb begin
        clr    = '0;
        mask_d = mask_q;
        if (wr_en && avs.address == 2'd3) begin
            clr = avs.writedata[WIDTH-1:0];
        end
        if (wr_en && avs.address == 2'd2) begin
            mask_d = avs.writedata[WIDTH-1:0];
        end
        edge_d = (edge_q & ~clr) | ev;
        irq_d  = |(edge_q & mask_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q <= '0;
            mask_q <= '0;
            edge_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            prev_q <= filt;
            mask_q <= mask_d;
            edge_q <= edge_d;
            irq_q  <= irq_d;
        end
    end

    assign irq = irq_q;

    always_comb begin
        avs.readdata = '0;
        case (avs.address)
            2'd0:    avs.readdata[WIDTH-1:0] = filt;
            2'd2:    avs.readdata[WIDTH-1:0] = mask_q;
            2'd3:    avs.readdata[WIDTH-1:0] = edge_q;
            default: avs.readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_qsys_arduino_irq_in.sv
// tb/tb_qsys_arduino_irq_in.sv - bench for qsys_arduino_irq_in, rising/falling/any-edge instances
module tb_qsys_arduino_irq_in;

    localparam int SYNC = 2;
`ifdef ARDUINO_IRQ_DEBOUNCE_EN
    localparam int DBC = 16;
`else
    localparam int DBC = 0;
`endif
    localparam int LAT = SYNC + 1 + DBC;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  in_port;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic        irq0, irq1, irq2;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    qsys_arduino_irq_in_if bus0 ();
    qsys_arduino_irq_in_if bus1 ();
    qsys_arduino_irq_in_if bus2 ();

    assign bus0.address = address;  assign bus0.chipselect = chipselect;
    assign bus0.write_n = write_n;  assign bus0.writedata  = writedata;
    assign bus1.address = address;  assign bus1.chipselect = chipselect;
    assign bus1.write_n = write_n;  assign bus1.writedata  = writedata;
    assign bus2.address = address;  assign bus2.chipselect = chipselect;
    assign bus2.write_n = write_n;  assign bus2.writedata  = writedata;

    qsys_arduino_irq_in #(.WIDTH(4), .SYNC_STAGES(SYNC), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(16)) dut0 (
        .clk(clk), .reset_n(reset_n), .avs(bus0.slave), .in_port(in_port), .irq(irq0));
    qsys_arduino_irq_in #(.WIDTH(4), .SYNC_STAGES(SYNC), .EDGE_TYPE(1), .DEBOUNCE_CYCLES(16)) dut1 (
        .clk(clk), .reset_n(reset_n), .avs(bus1.slave), .in_port(in_port), .irq(irq1));
    qsys_arduino_irq_in #(.WIDTH(4), .SYNC_STAGES(SYNC), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(16)) dut2 (
        .clk(clk), .reset_n(reset_n), .avs(bus2.slave), .in_port(in_port), .irq(irq2));

    // Reference model: line history as a sample queue, filtered value, capture/mask/irq per instance.
    logic [3:0] hist [$];
    logic [3:0] f_m, p_m, mask_m;
    logic [3:0] ec_m [3];
    logic       irq_m [3];
    int         run [4];

    task automatic model_reset();
        hist = {};
        repeat (SYNC) hist.push_front(4'h0);
        f_m = '0; p_m = '0; mask_m = '0;
        for (int d = 0; d < 3; d++) begin
            ec_m[d] = '0; irq_m[d] = 1'b0;
        end
        for (int b = 0; b < 4; b++) run[b] = 0;
    endtask

    task automatic model_step();
        logic [3:0] rise, fall, s_prev, f_new;
        logic       wr;
        rise = f_m & ~p_m;
        fall = ~f_m & p_m;
        wr   = chipselect & ~write_n;
        for (int d = 0; d < 3; d++) irq_m[d] = |(ec_m[d] & mask_m);
        for (int d = 0; d < 3; d++) begin
            if (wr && address == 2'd3) ec_m[d] = ec_m[d] & ~writedata[3:0];
        end
        ec_m[0] = ec_m[0] | rise;
        ec_m[1] = ec_m[1] | fall;
        ec_m[2] = ec_m[2] | rise | fall;
        if (wr && address == 2'd2) mask_m = writedata[3:0];
        s_prev = hist[SYNC-1];
        hist.push_front(in_port);
        void'(hist.pop_back());
`ifdef ARDUINO_IRQ_DEBOUNCE_EN
        f_new = f_m;
        for (int b = 0; b < 4; b++) begin
            if (s_prev[b] != f_m[b]) begin
                run[b]++;
                if (run[b] == DBC) begin
                    f_new[b] = s_prev[b];
                    run[b] = 0;
                end
            end else begin
                run[b] = 0;
            end
        end
`else
        f_new = hist[SYNC-1];
`endif
        p_m = f_m;
        f_m = f_new;
    endtask

    function automatic logic [31:0] exp_rd(int d, logic [1:0] a);
        case (a)
            2'd0:    return {28'h0, f_m};
            2'd2:    return {28'h0, mask_m};
            2'd3:    return {28'h0, ec_m[d]};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] rd_of(int d);
        case (d)
            0:       return bus0.readdata;
            1:       return bus1.readdata;
            default: return bus2.readdata;
        endcase
    endfunction

    function automatic logic irq_of(int d);
        case (d)
            0:       return irq0;
            1:       return irq1;
            default: return irq2;
        endcase
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic settle(int n);
        repeat (n) tick();
    endtask

    task automatic wr(logic [1:0] a, logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        tick();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic chk_rd(string tag, int d, logic [1:0] a, logic [31:0] exp);
        address = a;
        #1;
        chk(tag, rd_of(d), exp);
    endtask

    initial begin
        reset_n = 1'b0; in_port = 4'hF; address = '0; chipselect = 1'b0;
        write_n = 1'b1; writedata = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int a = 0; a < 4; a++) chk_rd("reset_rd", 0, 2'(a), 32'h0);
        chk("reset_irq", {31'h0, irq0}, 32'h0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        settle(LAT - 1);
        chk_rd("rst_rise_early", 0, 2'd3, 32'h0);
        tick();
        chk_rd("rst_rise_cap", 0, 2'd3, 32'hF);
        in_port = 4'h0;
        settle(LAT + 1);
        wr(2'd3, 32'hF);

        wr(2'd2, 32'hF);
        in_port = 4'h5;
        settle(LAT - 1);
        chk_rd("cap5_early", 0, 2'd3, 32'h0);
        tick();
        chk_rd("cap5", 0, 2'd3, 32'h5);
        chk("cap5_irq_lag", {31'h0, irq0}, 32'h0);
        tick();
        chk("cap5_irq", {31'h0, irq0}, 32'h1);
        wr(2'd3, 32'h1);
        chk_rd("clr1", 0, 2'd3, 32'h4);
        tick();
        chk("clr1_irq", {31'h0, irq0}, 32'h1);
        wr(2'd3, 32'h4);
        chk_rd("clr4", 0, 2'd3, 32'h0);
        chk("clr4_irq_lag", {31'h0, irq0}, 32'h1);
        tick();
        chk("clr4_irq", {31'h0, irq0}, 32'h0);

        wr(2'd2, 32'h0);
        in_port = 4'h4;
        settle(LAT + 1);
        wr(2'd3, 32'hF);
        in_port = 4'h5;
        settle(LAT);
        chk_rd("masked_cap", 0, 2'd3, 32'h1);
        tick();
        chk("masked_irq", {31'h0, irq0}, 32'h0);
        wr(2'd2, 32'h1);
        chk("unmask_irq_lag", {31'h0, irq0}, 32'h0);
        tick();
        chk("unmask_irq", {31'h0, irq0}, 32'h1);

        wr(2'd3, 32'hF);
        in_port = 4'h4;
        settle(LAT + 1);
        chk_rd("fall_rise_type", 0, 2'd3, 32'h0);
        chk_rd("fall_fall_type", 1, 2'd3, 32'h1);
        chk_rd("fall_any_type", 2, 2'd3, 32'h1);
        wr(2'd3, 32'hF);
        in_port = 4'h5;
        settle(LAT + 1);
        chk_rd("rise_rise_type", 0, 2'd3, 32'h1);
        chk_rd("rise_fall_type", 1, 2'd3, 32'h0);
        chk_rd("rise_any_type", 2, 2'd3, 32'h1);

        in_port = 4'h4;
        settle(LAT + 1);
        wr(2'd3, 32'hF);
        in_port = 4'h5;
        settle(LAT - 1);
        wr(2'd3, 32'h1);
        chk_rd("set_wins_rise", 0, 2'd3, 32'h1);
        chk_rd("set_wins_any", 2, 2'd3, 32'h1);

`ifdef ARDUINO_IRQ_DEBOUNCE_EN
        in_port = 4'h4;
        settle(LAT + 2);
        wr(2'd3, 32'hF);
        in_port = 4'h5;
        settle(10);
        in_port = 4'h4;
        settle(40);
        chk_rd("glitch_rd", 0, 2'd3, 32'h0);
        chk_rd("glitch_any", 2, 2'd3, 32'h0);
        in_port = 4'h5;
        settle(LAT - 1);
        chk_rd("deb_early", 0, 2'd3, 32'h0);
        tick();
        chk_rd("deb_cap", 0, 2'd3, 32'h1);
        chk_rd("deb_data", 0, 2'd0, 32'h5);
        settle(20);
        in_port = 4'h4;
`endif

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(2) == 0) in_port = 4'($urandom);
            address = 2'($urandom);
            if ($urandom_range(3) == 0) begin
                writedata = $urandom; chipselect = 1'b1; write_n = 1'b0;
            end else begin
                chipselect = 1'($urandom_range(1)); write_n = 1'b1;
            end
            #1;
            for (int d = 0; d < 3; d++) begin
                chk("rnd_irq", {31'h0, irq_of(d)}, {31'h0, irq_m[d]});
                chk("rnd_rd", rd_of(d), exp_rd(d, address));
            end
            tick();
        end
        chipselect = 1'b0; write_n = 1'b1;

        reset_n = 1'b0;
        #1;
        chk("midrst_irq", {29'h0, irq0, irq1, irq2}, 32'h0);
        chk_rd("midrst_ec", 2, 2'd3, 32'h0);
        chk_rd("midrst_mask", 0, 2'd2, 32'h0);
        chk_rd("midrst_data", 0, 2'd0, 32'h0);
        model_reset();
        @(posedge clk); #1;
        reset_n = 1'b1;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
